// File: rtl/button_debounce_if.sv
// Signal bundle between the raw button pad and the button_debounce conditioner.
// slave: the debouncer (samples button_i, drives the conditioned outputs); master: its user.
interface button_debounce_if;
  logic button_i;
  logic btn_level_o;
  logic press_o;
  logic release_o;
  logic long_press_o;

  modport slave (
    input  button_i,
    output btn_level_o,
    output press_o,
    output release_o,
    output long_press_o
  );

  modport master (
    output button_i,
    input  btn_level_o,
    input  press_o,
    input  release_o,
    input  long_press_o
  );
endinterface

// File: rtl/button_debounce.sv
// Synchronise, debounce and edge-detect an active-low mechanical button.
// Define LONG_PRESS_EN to build the long-press detector; otherwise long_press_o is tied low.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 64
) (
  input  logic          clk,
  input  logic          reset,
  button_debounce_if.slave bus
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, PRESSED, REL_CHK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             btn_s;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  assign btn_s = sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= bus.button_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!btn_s) begin
          state_d = PRESS_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_CHK: begin
        if (btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (btn_s) begin
          state_d = REL_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      REL_CHK: begin
        if (!btn_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulses come from comparing the current state with the registered level,
  // so press/release land in the same cycle the level changes.
  always_comb begin
    level_d   = (state_q == PRESSED) || (state_q == REL_CHK);
    press_d   = (state_q == PRESSED) && !level_q;
    release_d = (state_q == IDLE) && level_q;
  end

  assign bus.btn_level_o = level_q;
  assign bus.press_o     = press_q;
  assign bus.release_o   = release_q;

`ifdef LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES);

  logic [CNT_W-1:0] long_cnt_q, long_cnt_d;
  logic             long_done_q, long_done_d;
  logic             long_q, long_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      long_cnt_q  <= '0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      long_cnt_q  <= long_cnt_d;
      long_done_q <= long_done_d;
      long_q      <= long_d;
    end
  end

  // Counter only runs in PRESSED and holds through release bounces; done flag keeps it to one pulse.
  always_comb begin
    long_cnt_d  = long_cnt_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if (state_q == IDLE) begin
      long_cnt_d  = '0;
      long_done_d = 1'b0;
    end else if (state_q == PRESSED) begin
      if (long_cnt_q != LONG_LAST) begin
        long_cnt_d = long_cnt_q + CNT_ONE;
      end else if (!long_done_q) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end
    end
  end

  assign bus.long_press_o = long_q;
`else
  assign bus.long_press_o = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Inputs change and outputs are sampled on the falling edge; pulses are also tallied on rising edges.
module tb_button_debounce;

  localparam int DB = 4;
  localparam int LC = 20;
`ifdef LONG_PRESS_EN
  localparam int LP_EN = 1;
`else
  localparam int LP_EN = 0;
`endif

  logic clk;
  logic reset;
  int   checks_total  = 0;
  int   checks_passed = 0;
  int   press_seen    = 0;
  int   release_seen  = 0;
  int   long_seen     = 0;
  int   pb, rb, lb;

  button_debounce_if bif ();

  button_debounce #(
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bif.press_o)      press_seen++;
    if (bif.release_o)    release_seen++;
    if (bif.long_press_o) long_seen++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks_total++;
    if (got == exp) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset        = 1'b1;
    bif.button_i = 1'b0;

    // 1: button already low at reset release needs full debounce
    repeat (3) @(negedge clk);
    check("rst_level",   int'(bif.btn_level_o),  0);
    check("rst_press",   int'(bif.press_o),      0);
    check("rst_release", int'(bif.release_o),    0);
    check("rst_long",    int'(bif.long_press_o), 0);
    reset = 1'b0;
    for (int k = 0; k < DB + 2; k++) begin
      cycles(1);
      check("t1_press_early", int'(bif.press_o), 0);
    end
    cycles(1);
    check("t1_press",        int'(bif.press_o),     1);
    check("t1_level_rise",   int'(bif.btn_level_o), 1);
    cycles(1);
    check("t1_press_single", int'(bif.press_o),     0);
    check("t1_level_hold",   int'(bif.btn_level_o), 1);
    bif.button_i = 1'b1;
    for (int k = 0; k < DB + 2; k++) begin
      cycles(1);
      check("t1_release_early", int'(bif.release_o),   0);
      check("t1_level_pre_rel", int'(bif.btn_level_o), 1);
    end
    cycles(1);
    check("t1_release",      int'(bif.release_o),   1);
    check("t1_level_fall",   int'(bif.btn_level_o), 0);
    cycles(1);
    check("t1_release_single", int'(bif.release_o), 0);
    $display("test1 reset-held press/release done");

    // 2: 2-cycle glitch is rejected
    pb = press_seen;
    bif.button_i = 1'b0;
    cycles(2);
    bif.button_i = 1'b1;
    cycles(15);
    check("t2_no_press", press_seen - pb, 0);
    check("t2_level",    int'(bif.btn_level_o), 0);
    $display("test2 glitch rejection done");

    // 3: 10-cycle press, exact latency both ways (also proves FSM returned to IDLE)
    pb = press_seen;
    rb = release_seen;
    bif.button_i = 1'b0;
    cycles(DB + 2);
    check("t3_press_early", int'(bif.press_o), 0);
    cycles(1);
    check("t3_press", int'(bif.press_o), 1);
    cycles(3);
    check("t3_level", int'(bif.btn_level_o), 1);
    bif.button_i = 1'b1;
    cycles(DB + 2);
    check("t3_release_early", int'(bif.release_o), 0);
    cycles(1);
    check("t3_release",    int'(bif.release_o),   1);
    check("t3_level_fall", int'(bif.btn_level_o), 0);
    cycles(3);
    check("t3_press_count",   press_seen - pb,   1);
    check("t3_release_count", release_seen - rb, 1);
    $display("test3 10-cycle press done");

    // 4: release bounce high 2, low 1, then high
    bif.button_i = 1'b0;
    cycles(DB + 4);
    check("t4_level_pressed", int'(bif.btn_level_o), 1);
    rb = release_seen;
    bif.button_i = 1'b1;
    cycles(2);
    check("t4_level_bounce_hi", int'(bif.btn_level_o), 1);
    bif.button_i = 1'b0;
    cycles(1);
    check("t4_level_bounce_lo", int'(bif.btn_level_o), 1);
    bif.button_i = 1'b1;
    for (int k = 0; k < DB + 2; k++) begin
      cycles(1);
      check("t4_level_hold",   int'(bif.btn_level_o), 1);
      check("t4_release_early", int'(bif.release_o),  0);
    end
    cycles(1);
    check("t4_release",    int'(bif.release_o),   1);
    check("t4_level_fall", int'(bif.btn_level_o), 0);
    cycles(3);
    check("t4_release_count", release_seen - rb, 1);
    $display("test4 release bounce done");

    // 5: 40-cycle hold, long press 20 cycles after the press pulse
    lb = long_seen;
    bif.button_i = 1'b0;
    cycles(DB + 3);
    check("t5_press", int'(bif.press_o), 1);
    for (int k = 0; k < LC - 1; k++) begin
      cycles(1);
      check("t5_long_early", int'(bif.long_press_o), 0);
    end
    cycles(1);
    check("t5_long",        int'(bif.long_press_o), LP_EN);
    cycles(1);
    check("t5_long_single", int'(bif.long_press_o), 0);
    cycles(12);
    check("t5_long_count_held", long_seen - lb, LP_EN);
    bif.button_i = 1'b1;
    cycles(10);
    check("t5_level_after", int'(bif.btn_level_o), 0);
    check("t5_long_count",  long_seen - lb, LP_EN);
    $display("test5 long press done");

    // 6: async reset mid-PRESSED suppresses release
    bif.button_i = 1'b0;
    cycles(10);
    check("t6_level_pressed", int'(bif.btn_level_o), 1);
    pb = press_seen;
    rb = release_seen;
    #2;
    reset = 1'b1;
    #1;
    check("t6_level_async", int'(bif.btn_level_o), 0);
    check("t6_release_async", int'(bif.release_o), 0);
    bif.button_i = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(20);
    check("t6_no_press",   press_seen - pb,   0);
    check("t6_no_release", release_seen - rb, 0);
    check("t6_level",      int'(bif.btn_level_o), 0);
    $display("test6 reset mid-press done");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
